// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ifu_fetch_ctrl_pkg;

    localparam int unsigned IFU_CPU_WIDTH = 32;
    localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
    localparam int unsigned IFU_PC_INC    = 4;

    typedef enum logic [1:0] {
        IFU_ST_IDLE = 2'd0,
        IFU_ST_REQ  = 2'd1,
        IFU_ST_WAIT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_pc_gen.sv
// Program counter register: reset / redirect / sequential increment / hold.
module ifu_pc_gen
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int unsigned          CPU_WIDTH = IFU_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_en,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    input  logic                 inc_en,
    input  logic [CPU_WIDTH-1:0] inc_base,
    output logic [CPU_WIDTH-1:0] pc
);

    // Next-pc mux; redirect wins over the sequential step, target is word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_en) begin
            pc <= redirect_pc & ~CPU_WIDTH'(3);
        end else if (inc_en) begin
            pc <= inc_base + CPU_WIDTH'(IFU_PC_INC);
        end
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: one outstanding fetch over req/gnt/rvalid,
// delivers instruction + PC to decode as a one-cycle pulse, squashes on redirect.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int unsigned          CPU_WIDTH = IFU_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFU_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 redirect_en,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic                 ifu_start_en,
    output logic                 ifu_done_en,
    output logic [CPU_WIDTH-1:0] ifu_inst_pc,
    output logic [CPU_WIDTH-1:0] ifu_inst
);

    ifu_state_e           state;
    logic                 kill;
    logic [CPU_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0] fetch_pc;
    logic                 deliver;

    // A response is delivered only if neither an earlier nor a same-cycle redirect squashed it.
    always_comb begin
        deliver = (state == IFU_ST_WAIT) && imem_rvalid && !kill && !redirect_en;
    end

    ifu_pc_gen #(
        .CPU_WIDTH (CPU_WIDTH),
        .RESET_PC  (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .inc_en      (deliver),
        .inc_base    (fetch_pc),
        .pc          (pc)
    );

    // Fetch FSM plus the registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IFU_ST_IDLE;
            kill        <= 1'b0;
            fetch_pc    <= '0;
            ifu_done_en <= 1'b0;
            ifu_inst    <= '0;
            ifu_inst_pc <= '0;
        end else begin
            ifu_done_en <= deliver;
            if (deliver) begin
                ifu_inst    <= imem_rdata;
                ifu_inst_pc <= fetch_pc;
            end
            case (state)
                IFU_ST_IDLE: begin
                    if (enable) state <= IFU_ST_REQ;
                end
                IFU_ST_REQ: begin
                    if (imem_gnt) begin
                        state    <= IFU_ST_WAIT;
                        fetch_pc <= pc;
                        kill     <= redirect_en;
                    end else if (!enable) begin
                        state <= IFU_ST_IDLE;
                    end
                end
                IFU_ST_WAIT: begin
                    if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= enable ? IFU_ST_REQ : IFU_ST_IDLE;
                    end else if (redirect_en) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IFU_ST_IDLE;
            endcase
        end
    end

    assign imem_req     = (state == IFU_ST_REQ);
    assign imem_addr    = pc & ~CPU_WIDTH'(3);
    assign ifu_start_en = imem_req && imem_gnt && !redirect_en;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifu_start_en;
    logic        ifu_done_en;
    logic [31:0] ifu_inst_pc;
    logic [31:0] ifu_inst;

    ifu_fetch_ctrl #(
        .CPU_WIDTH (32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .ifu_start_en (ifu_start_en),
        .ifu_done_en  (ifu_done_en),
        .ifu_inst_pc  (ifu_inst_pc),
        .ifu_inst     (ifu_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the fetches in flight, the next fetch address and
    // whether the unit is trying to fetch.
    typedef struct {
        logic [31:0] pc;
        bit          squashed;
    } fetch_t;

    fetch_t      inflight[$];
    logic [31:0] m_pc      = 32'h0;
    bit          m_run     = 1'b0;
    logic        m_done    = 1'b0;
    logic [31:0] m_inst    = 32'h0;
    logic [31:0] m_inst_pc = 32'h0;

    // Memory responder: one pending response, fixed or random latency.
    bit          mem_pend  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_data  = 32'h0;
    int          lat       = 1;
    bit          lat_rand  = 1'b0;
    bit          mem_fixed = 1'b1;
    int          gnt_mode  = 1;   // 0 never, 1 always, 2 random

    logic [31:0] dq[$];           // PCs of DUT done pulses
    logic        s_req, s_start, s_done;
    logic [31:0] s_addr, s_inst, s_inst_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        exp_req;
        logic        exp_start;
        logic [31:0] exp_addr;
        logic        deliver;
        fetch_t      e;
        imem_gnt    = !rst && !mem_pend &&
                      (gnt_mode == 1 || (gnt_mode == 2 && $urandom_range(0, 1) == 1));
        imem_rvalid = mem_pend && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_data : $urandom;
        exp_req     = m_run && (inflight.size() == 0);
        exp_addr    = m_pc & ~32'h3;
        exp_start   = exp_req && imem_gnt && !redirect_en;
        #4;
        s_req = imem_req; s_start = ifu_start_en; s_done = ifu_done_en;
        s_addr = imem_addr; s_inst = ifu_inst; s_inst_pc = ifu_inst_pc;
        chk("imem_req",     {31'b0, imem_req},     {31'b0, exp_req});
        chk("imem_addr",    imem_addr,             exp_addr);
        chk("ifu_start_en", {31'b0, ifu_start_en}, {31'b0, exp_start});
        chk("ifu_done_en",  {31'b0, ifu_done_en},  {31'b0, m_done});
        chk("ifu_inst",     ifu_inst,              m_inst);
        chk("ifu_inst_pc",  ifu_inst_pc,           m_inst_pc);
        if (ifu_done_en === 1'b1) dq.push_back(ifu_inst_pc);
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            m_pc = 32'h0; m_run = 1'b0; m_done = 1'b0; m_inst = 32'h0; m_inst_pc = 32'h0;
        end else begin
            deliver = 1'b0;
            e.pc = 32'h0; e.squashed = 1'b0;
            if (inflight.size() > 0 && imem_rvalid) begin
                e = inflight.pop_front();
                deliver = !e.squashed && !redirect_en;
            end else if (exp_req && imem_gnt) begin
                e.pc = m_pc; e.squashed = redirect_en;
                inflight.push_back(e);
            end
            if (redirect_en) foreach (inflight[k]) inflight[k].squashed = 1'b1;
            m_done = deliver;
            if (deliver) begin
                m_inst = imem_rdata; m_inst_pc = e.pc;
            end
            if (redirect_en)  m_pc = redirect_pc & ~32'h3;
            else if (deliver) m_pc = e.pc + 32'd4;
            if (inflight.size() == 0) m_run = enable;
        end
        if (imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (exp_req && imem_gnt && !rst) begin
            if (lat_rand) lat = $urandom_range(1, 3);
            mem_pend = 1'b1;
            mem_cnt  = lat - 1;
            mem_data = mem_fixed ? 32'h0000_0013 : $urandom;
        end
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30 && !(m_run && inflight.size() == 0); i++) step();
        chk("reach_req", {31'b0, (m_run && inflight.size() == 0)}, 32'd1);
    endtask

    task automatic wait_wait();
        for (int i = 0; i < 30 && inflight.size() == 0; i++) step();
        chk("reach_wait", {31'b0, (inflight.size() > 0)}, 32'd1);
    endtask

    task automatic run_until(input int n);
        for (int i = 0; i < 40 && dq.size() < n; i++) step();
        chk("done_count", dq.size(), n);
    endtask

    initial begin
        logic [31:0] save_pc;
        int          n;
        rst = 1'b1; enable = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        step(); step();

        // Sequential fetch from reset: 0x0, 0x4, 0x8 with the fixed NOP word.
        enable = 1'b1;
        dq.delete();
        run_until(3);
        chk("seq_pc0", dq[0], 32'h0);
        chk("seq_pc1", dq[1], 32'h4);
        chk("seq_pc2", dq[2], 32'h8);
        chk("seq_inst", s_inst, 32'h0000_0013);

        // Redirect while waiting: pending response dropped, resume at 0x100.
        wait_wait();
        redirect_en = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_en = 1'b0;
        dq.delete();
        run_until(1);
        chk("redir_wait_pc", dq[0], 32'h100);

        // Redirect coinciding with req&gnt at 0x8.
        wait_req();
        redirect_en = 1'b1; redirect_pc = 32'h8;
        step();
        redirect_en = 1'b0;
        for (int i = 0; i < 30 && !(m_run && inflight.size() == 0 && m_pc == 32'h8); i++) step();
        redirect_en = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_en = 1'b0;
        chk("redir_gnt_req",   {31'b0, s_req},   32'd1);
        chk("redir_gnt_addr",  s_addr,           32'h8);
        chk("redir_gnt_start", {31'b0, s_start}, 32'd0);
        dq.delete();
        run_until(1);
        chk("redir_gnt_pc", dq[0], 32'h200);

        // Grant withheld, then enable dropped; resume at the same pc.
        gnt_mode = 0;
        wait_req();
        repeat (5) step();
        chk("stall_req",   {31'b0, s_req},   32'd1);
        chk("stall_start", {31'b0, s_start}, 32'd0);
        save_pc = m_pc;
        enable = 1'b0;
        step(); step();
        chk("disable_req", {31'b0, s_req}, 32'd0);
        n = dq.size();
        repeat (3) step();
        chk("disable_no_done", dq.size(), n);
        enable = 1'b1; gnt_mode = 1;
        dq.delete();
        run_until(1);
        chk("resume_pc", dq[0], save_pc);

        // Reset during WAIT with a slow memory; stale rvalid must be ignored.
        lat = 3;
        wait_wait();
        rst = 1'b1; enable = 1'b0;
        step();
        rst = 1'b0;
        dq.delete();
        repeat (4) step();
        chk("rst_no_done",  dq.size(), 0);
        chk("rst_inst",     s_inst,    32'h0);
        chk("rst_inst_pc",  s_inst_pc, 32'h0);
        lat = 1; enable = 1'b1;
        run_until(1);
        chk("rst_restart_pc", dq[0], 32'h0);

        // PC wrap at the top of the address space.
        wait_req();
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_en = 1'b0;
        dq.delete();
        run_until(2);
        chk("wrap_pc0", dq[0], 32'hFFFF_FFFC);
        chk("wrap_pc1", dq[1], 32'h0000_0000);

        // Randomized traffic.
        gnt_mode = 2; lat_rand = 1'b1; mem_fixed = 1'b0;
        for (int i = 0; i < 600; i++) begin
            enable      = ($urandom_range(0, 7) != 0);
            redirect_en = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            step();
        end
        redirect_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
